decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port instruction, input, 32 bits: RV32I instruction word to decode.
REQ-004 SHALL have port opcode, output, 7 bits: instruction[6:0].
REQ-005 SHALL have port rd, output, 5 bits: instruction[11:7].
REQ-006 SHALL have port funct3, output, 3 bits: instruction[14:12].
REQ-007 SHALL have port rs1, output, 5 bits: instruction[19:15].
REQ-008 SHALL have port rs2, output, 5 bits: instruction[24:20].
REQ-009 SHALL have port funct7, output, 7 bits: instruction[31:25].
REQ-010 SHALL have port imm, output, 32 bits: sign-extended immediate for the decoded format.
REQ-011 SHALL have port fmt, output, 3 bits: format code, one of R, I, S, B, U, J or NONE.
REQ-012 SHALL have port writes_rd, output, 1 bit: the instruction writes rd and rd != 0.
REQ-013 SHALL have port illegal, output, 1 bit: the opcode or funct combination is not supported.
REQ-014 SHALL have port illegal_sticky, output, 1 bit: registered flag, set once any illegal instruction has been decoded.

Function
REQ-015 Field outputs (opcode, rd, funct3, rs1, rs2, funct7) SHALL be raw combinational bit slices, always driven regardless of format, with zero latency.
REQ-016 Supported opcodes:
- 0110011 ALU-R -> R
- 0010011 ALU-I -> I
- 0000011 LOAD -> I
- 0100011 STORE -> S
- 1100011 BRANCH -> B
- 0110111 LUI -> U
- 0010111 AUIPC -> U
- 1101111 JAL -> J
- 1100111 JALR -> I
REQ-017 imm by format, all signed from instruction[31]:
- I: {20x i[31], i[31:20]}
- S: {20x i[31], i[31:25], i[11:7]}
- B: {19x i[31], i[31], i[7], i[30:25], i[11:8], 0}
- U: {i[31:12], 12 zeros}
- J: {11x i[31], i[31], i[19:12], i[20], i[30:21], 0}
- R and NONE: 0
REQ-018 illegal SHALL be 1 in these cases:
- unsupported opcode; fmt = NONE and imm = 0.
- ALU-R with funct7 not in {0000000, 0100000}.
- ALU-R with funct7 = 0100000 and funct3 not in {000, 101}.
- LOAD with funct3 in {011, 110, 111}.
- STORE with funct3 > 010.
- BRANCH with funct3 in {010, 011}.
- JALR with funct3 != 000.
- ALU-I shifts (funct3 001 or 101) with a bad funct7.
REQ-019 writes_rd SHALL be 1 only for R, I, U and J formats, when illegal = 0 and rd != 0.
REQ-020 All combinational outputs SHALL depend only on the current instruction; there are no X outputs for any 32-bit input.
REQ-021 illegal_sticky SHALL become 1 on the first rising edge where illegal = 1 and reset = 0, and SHALL stay 1 until reset.
REQ-022 If reset and illegal are both 1 on the same edge, reset SHALL win and illegal_sticky SHALL be 0.

Reset
REQ-023 On a rising edge with reset = 1, illegal_sticky SHALL be 0 on the following cycle.
REQ-024 Combinational outputs SHALL be unaffected by reset.

Structure
REQ-025 Opcode constants (ALUopR, ALUopI, LW, SW, BEQ, LUI, AUIPC, JAL, JALR) and the fmt enum SHALL live in the shared opcodes package.
REQ-026 Immediate generation SHALL be a single sub-module, imm_gen (inputs: instruction and fmt; output: imm); there SHALL be no other sub-modules.

Verification
REQ-027 add x3,x1,x2, instruction 0x002081B3, SHALL give:
- opcode 0110011, rd 3, funct3 0, rs1 1, rs2 2, funct7 0
- fmt R, imm 0, writes_rd 1, illegal 0
REQ-028 beq x1,x2,-8, instruction 0xFE208CE3, SHALL give fmt B, imm 0xFFFFFFF8, rs1 1, rs2 2, writes_rd 0.
REQ-029 sw x2,12(x1), instruction 0x0020A623, SHALL give fmt S, imm 12.
REQ-030 lw x5,-4(x1), instruction 0xFFC0A283, SHALL give fmt I, imm 0xFFFFFFFC, rd 5, writes_rd 1.
REQ-031 Instruction 0xFFFFFFFF SHALL give illegal 1 and fmt NONE, then illegal_sticky 1 after the next edge; illegal_sticky SHALL remain 1 with legal instructions applied and clear to 0 after a reset edge.
REQ-032 addi x0,x0,0, instruction 0x00000013, SHALL give writes_rd 0 and illegal 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared RV32I opcode constants and instruction-format encoding for the decoder.
package decoder_pkg;

  localparam logic [6:0] ALUopR = 7'b0110011;
  localparam logic [6:0] ALUopI = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BEQ    = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

endpackage

// File: rtl/decoder_imm_gen.sv
// Sign-extended immediate assembly for each RV32I instruction format.
module imm_gen
  import decoder_pkg::*;
(
  input  logic [31:0] instruction,
  input  fmt_e        fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'd0;
    case (fmt)
      FMT_I: imm = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S: imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: imm = {instruction[31:12], 12'd0};
      FMT_J: imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decoder.sv
// RV32I instruction decoder: field slices, format/immediate, legality check and
// a sticky flag remembering that an illegal instruction was ever seen.
module decoder
  import decoder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [2:0]  fmt,
  output logic        writes_rd,
  output logic        illegal,
  output logic        illegal_sticky
);

  fmt_e fmt_next;
  logic illegal_next;
  logic illegal_sticky_reg;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  always_comb begin
    fmt_next     = FMT_NONE;
    illegal_next = 1'b0;
    case (opcode)
      ALUopR: begin
        fmt_next = FMT_R;
        if (funct7 == 7'b0100000)
          illegal_next = !(funct3 == 3'b000 || funct3 == 3'b101);
        else
          illegal_next = (funct7 != 7'b0000000);
      end
      ALUopI: begin
        fmt_next = FMT_I;
        // Shift-amount encodings reuse the funct7 field; only SRAI may set bit 30.
        if (funct3 == 3'b001)
          illegal_next = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          illegal_next = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
      end
      LW: begin
        fmt_next     = FMT_I;
        illegal_next = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      SW: begin
        fmt_next     = FMT_S;
        illegal_next = (funct3 > 3'b010);
      end
      BEQ: begin
        fmt_next     = FMT_B;
        illegal_next = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      LUI, AUIPC: fmt_next = FMT_U;
      JAL:        fmt_next = FMT_J;
      JALR: begin
        fmt_next     = FMT_I;
        illegal_next = (funct3 != 3'b000);
      end
      default: begin
        fmt_next     = FMT_NONE;
        illegal_next = 1'b1;
      end
    endcase
  end

  imm_gen u_imm_gen (
    .instruction (instruction),
    .fmt         (fmt_next),
    .imm         (imm)
  );

  assign fmt       = fmt_next;
  assign illegal   = illegal_next;
  assign writes_rd = !illegal_next && (rd != 5'd0) &&
                     (fmt_next == FMT_R || fmt_next == FMT_I ||
                      fmt_next == FMT_U || fmt_next == FMT_J);

  always_ff @(posedge clock) begin
    if (reset)
      illegal_sticky_reg <= 1'b0;
    else if (illegal_next)
      illegal_sticky_reg <= 1'b1;
  end

  assign illegal_sticky = illegal_sticky_reg;

endmodule

// File: tb/tb_decoder.sv
// Directed testbench for the RV32I decoder with hand-computed expected values.
module tb_decoder;
  import decoder_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        writes_rd;
  logic        illegal;
  logic        illegal_sticky;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  decoder dut (
    .clock          (clock),
    .reset          (reset),
    .instruction    (instruction),
    .opcode         (opcode),
    .rd             (rd),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct7         (funct7),
    .imm            (imm),
    .fmt            (fmt),
    .writes_rd      (writes_rd),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instruction = 32'h002081B3;
    tick();
    tick();
    n_cmp++;
    if (illegal_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sticky: got %b want 0", illegal_sticky);
    end
    // combinational outputs must be live while reset is held
    n_cmp++;
    if (fmt !== 3'(FMT_R) || rd !== 5'd3 || writes_rd !== 1'b1) begin
      n_err++;
      $display("FAIL reset_comb: fmt=%0d rd=%0d wr=%b want fmt=%0d rd=3 wr=1", fmt, rd, writes_rd, FMT_R);
    end
    $display("reset: sticky=%b fmt=%0d", illegal_sticky, fmt);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    instruction = 32'h002081B3;
    #1;
    n_cmp++;
    if (opcode !== 7'b0110011 || rd !== 5'd3 || funct3 !== 3'd0 ||
        rs1 !== 5'd1 || rs2 !== 5'd2 || funct7 !== 7'd0) begin
      n_err++;
      $display("FAIL add_fields: op=%b rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%0d want 0110011 3 0 1 2 0",
               opcode, rd, funct3, rs1, rs2, funct7);
    end
    n_cmp++;
    if (fmt !== 3'(FMT_R) || imm !== 32'd0 || writes_rd !== 1'b1 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL add_ctrl: fmt=%0d imm=%h wr=%b ill=%b want %0d 0 1 0", fmt, imm, writes_rd, illegal, FMT_R);
    end
    $display("add x3,x1,x2: fmt=%0d imm=%h wr=%b ill=%b", fmt, imm, writes_rd, illegal);
  endtask

  task automatic test_immediates();
    logic [31:0] v_instr [9];
    logic [2:0]  v_fmt   [9];
    logic [31:0] v_imm   [9];
    logic        v_wr    [9];
    v_instr[0] = 32'hFE208CE3; v_fmt[0] = FMT_B; v_imm[0] = 32'hFFFFFFF8; v_wr[0] = 1'b0; // beq -8
    v_instr[1] = 32'h0020A623; v_fmt[1] = FMT_S; v_imm[1] = 32'd12;       v_wr[1] = 1'b0; // sw 12
    v_instr[2] = 32'hFFC0A283; v_fmt[2] = FMT_I; v_imm[2] = 32'hFFFFFFFC; v_wr[2] = 1'b1; // lw -4
    v_instr[3] = 32'h123450B7; v_fmt[3] = FMT_U; v_imm[3] = 32'h12345000; v_wr[3] = 1'b1; // lui
    v_instr[4] = 32'h00001297; v_fmt[4] = FMT_U; v_imm[4] = 32'h00001000; v_wr[4] = 1'b1; // auipc
    v_instr[5] = 32'h008000EF; v_fmt[5] = FMT_J; v_imm[5] = 32'd8;        v_wr[5] = 1'b1; // jal +8
    v_instr[6] = 32'hFFDFF0EF; v_fmt[6] = FMT_J; v_imm[6] = 32'hFFFFFFFC; v_wr[6] = 1'b1; // jal -4
    v_instr[7] = 32'h000100E7; v_fmt[7] = FMT_I; v_imm[7] = 32'd0;        v_wr[7] = 1'b1; // jalr
    v_instr[8] = 32'h00000013; v_fmt[8] = FMT_I; v_imm[8] = 32'd0;        v_wr[8] = 1'b0; // nop
    for (int i = 0; i < 9; i++) begin
      instruction = v_instr[i];
      #1;
      n_cmp++;
      if (fmt !== v_fmt[i] || imm !== v_imm[i] || writes_rd !== v_wr[i] || illegal !== 1'b0) begin
        n_err++;
        $display("FAIL imm_%0d: instr=%h fmt=%0d imm=%h wr=%b ill=%b want fmt=%0d imm=%h wr=%b ill=0",
                 i, v_instr[i], fmt, imm, writes_rd, illegal, v_fmt[i], v_imm[i], v_wr[i]);
      end
      $display("instr %h: fmt=%0d imm=%h wr=%b ill=%b", v_instr[i], fmt, imm, writes_rd, illegal);
    end
    instruction = 32'hFE208CE3;
    #1;
    n_cmp++;
    if (rs1 !== 5'd1 || rs2 !== 5'd2) begin
      n_err++;
      $display("FAIL beq_regs: rs1=%0d rs2=%0d want 1 2", rs1, rs2);
    end
    instruction = 32'hFFC0A283;
    #1;
    n_cmp++;
    if (rd !== 5'd5) begin
      n_err++;
      $display("FAIL lw_rd: rd=%0d want 5", rd);
    end
  endtask

  task automatic test_legality();
    logic [31:0] v_instr [11];
    logic        v_ill   [11];
    v_instr[0]  = 32'h022081B3; v_ill[0]  = 1'b1; // funct7 0000001
    v_instr[1]  = 32'h402081B3; v_ill[1]  = 1'b0; // sub
    v_instr[2]  = 32'h402091B3; v_ill[2]  = 1'b1; // 0100000 with funct3 001
    v_instr[3]  = 32'h4020D1B3; v_ill[3]  = 1'b0; // sra
    v_instr[4]  = 32'h4010D093; v_ill[4]  = 1'b0; // srai
    v_instr[5]  = 32'h40109093; v_ill[5]  = 1'b1; // slli with bit 30
    v_instr[6]  = 32'h0000B283; v_ill[6]  = 1'b1; // load funct3 011
    v_instr[7]  = 32'h0000C283; v_ill[7]  = 1'b0; // lbu
    v_instr[8]  = 32'h0020B623; v_ill[8]  = 1'b1; // store funct3 011
    v_instr[9]  = 32'h0020A063; v_ill[9]  = 1'b1; // branch funct3 010
    v_instr[10] = 32'h000090E7; v_ill[10] = 1'b1; // jalr funct3 001
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      instruction = v_instr[i];
      #1;
      n_cmp++;
      if (illegal !== v_ill[i] || (v_ill[i] && writes_rd !== 1'b0)) begin
        n_err++;
        $display("FAIL legal_%0d: instr=%h ill=%b wr=%b want ill=%b", i, v_instr[i], illegal, writes_rd, v_ill[i]);
      end
      $display("instr %h: ill=%b wr=%b", v_instr[i], illegal, writes_rd);
    end
    tick();
    reset = 1'b0;
    instruction = 32'h00000013;
    tick();
  endtask

  task automatic test_sticky();
    instruction = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if (illegal !== 1'b1 || fmt !== 3'(FMT_NONE) || imm !== 32'd0 || illegal_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL all_ones: ill=%b fmt=%0d imm=%h sticky=%b want 1 0 0 0", illegal, fmt, imm, illegal_sticky);
    end
    tick();
    n_cmp++;
    if (illegal_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_set: got %b want 1", illegal_sticky);
    end
    instruction = 32'h002081B3;
    tick();
    tick();
    n_cmp++;
    if (illegal_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_hold: got %b want 1", illegal_sticky);
    end
    $display("sticky after legal: %b", illegal_sticky);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (illegal_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_clear: got %b want 0", illegal_sticky);
    end
    // reset must beat a simultaneous illegal
    instruction = 32'hFFFFFFFF;
    reset = 1'b1;
    tick();
    n_cmp++;
    if (illegal_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_reset_wins: got %b want 0", illegal_sticky);
    end
    reset = 1'b0;
    instruction = 32'h00000013;
    tick();
    n_cmp++;
    if (illegal_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_legal_only: got %b want 0", illegal_sticky);
    end
    $display("sticky after reset race: %b", illegal_sticky);
  endtask

  initial begin
    reset = 1'b1;
    instruction = 32'd0;
    test_reset();
    test_add();
    test_immediates();
    test_legality();
    test_sticky();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
